lcd_bus_driver: RTL



---
 rtl/lcd_pkg.sv | 38 +++
 rtl/lcd_bus_driver_if.sv | 11 +
 rtl/lcd_delay_counter.sv | 28 ++
 rtl/lcd_bus_driver.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus driver: command-word bit positions,
// FSM state encoding, the power-up init sequence and the long-command test.
// Optional power-up init is compiled in with LCD_POWERUP_INIT_EN.
package lcd_pkg;

  localparam int BACKLIGHT = 11;
  localparam int EN        = 10;
  localparam int RS        = 9;
  localparam int RW        = 8;

  localparam int INIT_LEN  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ENABLE,
    ST_HOLD,
    ST_EXEC_WAIT,
    ST_INIT_WAIT,
    ST_INIT_ISSUE
  } lcd_state_e;

  // Init sequence: 8-bit/2-line, display on, clear, entry mode increment.
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_bus_driver_if.sv
// Command handshake between the custom-instruction controller (master)
// and the LCD bus driver (slave).
interface lcd_bus_driver_if;
  logic [11:0] command;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        done;

  modport master (output command, output cmd_valid, input cmd_ready, input done);
  modport slave  (input command, input cmd_valid, output cmd_ready, output done);
endinterface

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter with zero flag; one instance times every state.
module lcd_delay_counter #(
  parameter int            CW      = 8,
  parameter logic [CW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= RST_VAL;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 8-bit parallel write driver. Turns accepted commands into timed
// setup / enable / hold bus cycles followed by the controller execution wait.
// Define LCD_POWERUP_INIT_EN to add the power-up wait and init sequence.
//
// state         | meaning
// IDLE          | cmd_ready high, pins hold last transfer
// SETUP         | rs/rw/data valid, lcd_en low
// ENABLE        | lcd_en high
// HOLD          | lcd_en low, data held
// EXEC_WAIT     | LCD executing; long wait for clear/home
// INIT_WAIT     | power-up delay (init build only)
// INIT_ISSUE    | load next init byte onto the pins (init build only)
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int T_SETUP_CYC   = 2,
  parameter int T_EN_CYC      = 12,
  parameter int T_HOLD_CYC    = 1,
  parameter int T_EXEC_CYC    = 2000,
  parameter int T_CLEAR_CYC   = 80000,
  parameter int T_POWERUP_CYC = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  lcd_bus_driver_if.slave         cmd,
  output logic [7:0]              lcd_data,
  output logic                    lcd_rs,
  output logic                    lcd_rw,
  output logic                    lcd_en,
  output logic                    lcd_backlight
);

  localparam int M0   = (T_SETUP_CYC > T_EN_CYC) ? T_SETUP_CYC : T_EN_CYC;
  localparam int M1   = (M0 > T_HOLD_CYC) ? M0 : T_HOLD_CYC;
  localparam int M2   = (M1 > T_EXEC_CYC) ? M1 : T_EXEC_CYC;
  localparam int M3   = (M2 > T_CLEAR_CYC) ? M2 : T_CLEAR_CYC;
  localparam int MAXP = (M3 > T_POWERUP_CYC) ? M3 : T_POWERUP_CYC;
  localparam int CW   = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] LD_SETUP   = CW'(T_SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_EN      = CW'(T_EN_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD    = CW'(T_HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_EXEC    = CW'(T_EXEC_CYC - 1);
  localparam logic [CW-1:0] LD_CLEAR   = CW'(T_CLEAR_CYC - 1);
`ifdef LCD_POWERUP_INIT_EN
  localparam logic [CW-1:0] LD_POWERUP = CW'(T_POWERUP_CYC - 1);
  localparam lcd_state_e    ST_RESET   = ST_INIT_WAIT;
`else
  localparam logic [CW-1:0] LD_POWERUP = '0;
  localparam lcd_state_e    ST_RESET   = ST_IDLE;
`endif

  lcd_state_e    state_q;
  logic          cmd_ready_q;
  logic          done_q;
  logic [7:0]    lcd_data_q;
  logic          lcd_rs_q;
  logic          lcd_rw_q;
  logic          lcd_en_q;
  logic          lcd_backlight_q;
`ifdef LCD_POWERUP_INIT_EN
  logic          init_busy_q;
  logic [1:0]    init_idx_q;
`endif

  logic          accept;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_zero;

  assign accept = (state_q == ST_IDLE) && cmd_ready_q && cmd.cmd_valid;

  lcd_delay_counter #(.CW(CW), .RST_VAL(LD_POWERUP)) u_delay (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  // Reload the shared counter with (N-1) on entry to each timed state.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept && cmd.command[EN]) begin
          cnt_load = 1'b1;
          cnt_val  = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = LD_EN;
        end
      end
      ST_ENABLE: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = is_long_cmd(lcd_rs_q, lcd_data_q) ? LD_CLEAR : LD_EXEC;
        end
      end
      ST_INIT_ISSUE: begin
        cnt_load = 1'b1;
        cnt_val  = LD_SETUP;
      end
      default: ;
    endcase
  end

  // Bus-cycle sequencer; all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_RESET;
      cmd_ready_q     <= 1'b0;
      done_q          <= 1'b0;
      lcd_data_q      <= 8'h00;
      lcd_rs_q        <= 1'b0;
      lcd_rw_q        <= 1'b0;
      lcd_en_q        <= 1'b0;
      lcd_backlight_q <= 1'b0;
`ifdef LCD_POWERUP_INIT_EN
      init_busy_q     <= 1'b1;
      init_idx_q      <= 2'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            lcd_backlight_q <= cmd.command[BACKLIGHT];
            if (cmd.command[EN]) begin
              lcd_data_q  <= cmd.command[7:0];
              lcd_rs_q    <= cmd.command[RS];
              lcd_rw_q    <= cmd.command[RW];
              cmd_ready_q <= 1'b0;
              state_q     <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (cnt_zero) begin
            lcd_en_q <= 1'b1;
            state_q  <= ST_ENABLE;
          end
        end
        ST_ENABLE: begin
          if (cnt_zero) begin
            lcd_en_q <= 1'b0;
            state_q  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_zero) state_q <= ST_EXEC_WAIT;
        end
        ST_EXEC_WAIT: begin
          if (cnt_zero) begin
`ifdef LCD_POWERUP_INIT_EN
            if (init_busy_q) begin
              if (init_idx_q == 2'(INIT_LEN - 1)) begin
                init_busy_q <= 1'b0;
                cmd_ready_q <= 1'b1;
                state_q     <= ST_IDLE;
              end else begin
                init_idx_q  <= init_idx_q + 2'd1;
                state_q     <= ST_INIT_ISSUE;
              end
            end else begin
              done_q      <= 1'b1;
              cmd_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
`else
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
`endif
          end
        end
`ifdef LCD_POWERUP_INIT_EN
        ST_INIT_WAIT: begin
          if (cnt_zero) state_q <= ST_INIT_ISSUE;
        end
        ST_INIT_ISSUE: begin
          lcd_data_q      <= init_byte(init_idx_q);
          lcd_rs_q        <= 1'b0;
          lcd_rw_q        <= 1'b0;
          lcd_backlight_q <= 1'b1;
          state_q         <= ST_SETUP;
        end
`endif
        default: state_q <= ST_RESET;
      endcase
    end
  end

  assign cmd.cmd_ready  = cmd_ready_q;
  assign cmd.done       = done_q;
  assign lcd_data       = lcd_data_q;
  assign lcd_rs         = lcd_rs_q;
  assign lcd_rw         = lcd_rw_q;
  assign lcd_en         = lcd_en_q;
  assign lcd_backlight  = lcd_backlight_q;

endmodule
